conv_tile_sched: RTL and testbench

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

---
 rtl/conv_tile_sched_if.sv | 26 ++
 rtl/conv_tile_sched.sv | 109 ++++++++++
 tb/tb_conv_tile_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between a job requester and the convolution tile scheduler.
// The requester side drives the job and engine status, the scheduler side drives tile control.
interface conv_tile_sched_if #(
    parameter int TILE_CNT_W = 16
);
    logic                  sched_start;
    logic [TILE_CNT_W-1:0] num_tiles;
    logic                  done_ack;
    logic                  eng_end_conv;
    logic                  wb_idle;
    logic                  tile_start;
    logic [TILE_CNT_W-1:0] tile_idx;
    logic                  sched_busy;
    logic                  sched_done;
    logic [31:0]           busy_cycles;

    modport master (
        output sched_start, num_tiles, done_ack, eng_end_conv, wb_idle,
        input  tile_start, tile_idx, sched_busy, sched_done, busy_cycles
    );

    modport slave (
        input  sched_start, num_tiles, done_ack, eng_end_conv, wb_idle,
        output tile_start, tile_idx, sched_busy, sched_done, busy_cycles
    );
endinterface

// File: rtl/conv_tile_sched.sv
// Sequences a convolution job tile by tile: issue, run, drain, done.
// Define SCHED_PERF_CNT_EN to build the busy_cycles performance counter.
module conv_tile_sched #(
    parameter int TILE_CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_tile_sched_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [TILE_CNT_W-1:0] cnt_q, cnt_d;
    logic [TILE_CNT_W-1:0] idx_q, idx_d;
    logic                  start_acc;
    logic                  last_tile;

    assign start_acc = (state_q == IDLE) && bus.sched_start;
    assign last_tile = (idx_q == cnt_q - TILE_CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sched_start) begin
                    cnt_d   = bus.num_tiles;
                    idx_d   = '0;
                    state_d = (bus.num_tiles == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                if (bus.eng_end_conv) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.wb_idle) begin
                    if (last_tile) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + TILE_CNT_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                // a start seen together with the ack waits for IDLE
                if (bus.done_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        busy_d = busy_q;
        if (start_acc) begin
            busy_d = '0;
        end else if ((state_q == ISSUE || state_q == RUN ||
                      state_q == DRAIN) && busy_q != 32'hFFFF_FFFF) begin
            busy_d = busy_q + 32'd1;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    // outputs decode registered state only
    always_comb begin
        bus.tile_start = (state_q == ISSUE);
        bus.tile_idx   = idx_q;
        bus.sched_busy = (state_q != IDLE);
        bus.sched_done = (state_q == DONE);
`ifdef SCHED_PERF_CNT_EN
        bus.busy_cycles = busy_q;
`else
        bus.busy_cycles = '0;
`endif
    end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched with hand-computed expectations.
// Works with or without SCHED_PERF_CNT_EN defined.
module tb_conv_tile_sched;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    conv_tile_sched_if #(.TILE_CNT_W(16)) bus ();

    conv_tile_sched #(.TILE_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SCHED_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ts,
                           input logic bsy, input logic dn);
        chk({tag, ".tile_start"}, {31'd0, bus.tile_start}, {31'd0, ts});
        chk({tag, ".sched_busy"}, {31'd0, bus.sched_busy}, {31'd0, bsy});
        chk({tag, ".sched_done"}, {31'd0, bus.sched_done}, {31'd0, dn});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // entered in ISSUE; leaves the scheduler in its first DRAIN cycle
    task automatic tile(input string tag, input int idx, input int end_dly);
        chk_out({tag, ".issue"}, 1'b1, 1'b1, 1'b0);
        chk({tag, ".idx"}, {16'd0, bus.tile_idx}, idx);
        step();
        chk_out({tag, ".run"}, 1'b0, 1'b1, 1'b0);
        repeat (end_dly - 1) step();
        bus.eng_end_conv = 1'b1;
        step();
        bus.eng_end_conv = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.sched_start  = 1'b0;
        bus.num_tiles    = '0;
        bus.done_ack     = 1'b0;
        bus.eng_end_conv = 1'b0;
        bus.wb_idle      = 1'b1;
        repeat (3) step();
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.idx", {16'd0, bus.tile_idx}, 32'd0);
        chk("reset.busy_cycles", bus.busy_cycles, 32'd0);

        // three tiles, start accepted on first edge after reset release
        rst_n = 1'b1;
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd3;
        step();
        bus.sched_start = 1'b0;
        bus.num_tiles   = 16'd7;
        for (int i = 0; i < 3; i++) begin
            chk_out("j3.issue", 1'b1, 1'b1, 1'b0);
            chk("j3.idx", {16'd0, bus.tile_idx}, i);
            step();
            step();
            bus.sched_start = 1'b1;
            step();
            bus.sched_start = 1'b0;
            chk_out("j3.start_in_run", 1'b0, 1'b1, 1'b0);
            step();
            step();
            bus.eng_end_conv = 1'b1;
            step();
            bus.eng_end_conv = 1'b0;
            chk_out("j3.drain", 1'b0, 1'b1, 1'b0);
            step();
        end
        chk_out("j3.done", 1'b0, 1'b1, 1'b1);
        chk("j3.idx_done", {16'd0, bus.tile_idx}, 32'd2);
        chk("j3.busy_cycles", bus.busy_cycles, PERF ? 32'd21 : 32'd0);
        step();
        chk_out("j3.done_hold", 1'b0, 1'b1, 1'b1);

        // ack and start together: only return to IDLE
        bus.done_ack    = 1'b1;
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd2;
        step();
        bus.done_ack = 1'b0;
        chk_out("ackstart.idle", 1'b0, 1'b0, 1'b0);
        chk("ackstart.idx_hold", {16'd0, bus.tile_idx}, 32'd2);
        chk("ackstart.busy_hold", bus.busy_cycles, PERF ? 32'd21 : 32'd0);
        step();
        bus.sched_start = 1'b0;
        tile("j2a.t0", 0, 5);
        step();
        tile("j2a.t1", 1, 5);
        step();
        chk_out("j2a.done", 1'b0, 1'b1, 1'b1);
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;

        // engine pulse in IDLE is ignored
        bus.eng_end_conv = 1'b1;
        step();
        bus.eng_end_conv = 1'b0;
        chk_out("idle.eng", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("idle.eng2", 1'b0, 1'b0, 1'b0);

        // zero-tile job goes straight to DONE
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd0;
        step();
        bus.sched_start = 1'b0;
        chk_out("j0.done", 1'b0, 1'b1, 1'b1);
        chk("j0.idx", {16'd0, bus.tile_idx}, 32'd0);
        chk("j0.busy_cycles", bus.busy_cycles, 32'd0);
        step();
        chk_out("j0.no_ack_hold", 1'b0, 1'b1, 1'b1);
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;
        chk_out("j0.idle", 1'b0, 1'b0, 1'b0);

        // one tile with a slow write buffer
        bus.wb_idle     = 1'b0;
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd1;
        step();
        bus.sched_start = 1'b0;
        tile("j1.t0", 0, 5);
        for (int k = 0; k < 10; k++) begin
            chk_out("j1.drain_wait", 1'b0, 1'b1, 1'b0);
            bus.eng_end_conv = (k == 3);
            step();
        end
        bus.eng_end_conv = 1'b0;
        chk_out("j1.drain_last", 1'b0, 1'b1, 1'b0);
        bus.wb_idle = 1'b1;
        step();
        chk_out("j1.done", 1'b0, 1'b1, 1'b1);
        chk("j1.busy_cycles", bus.busy_cycles, PERF ? 32'd17 : 32'd0);
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;

        // reset during RUN of the second of four tiles
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd4;
        step();
        bus.sched_start = 1'b0;
        tile("j4.t0", 0, 5);
        step();
        chk_out("j4.t1_issue", 1'b1, 1'b1, 1'b0);
        chk("j4.t1_idx", {16'd0, bus.tile_idx}, 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk_out("rst_run", 1'b0, 1'b0, 1'b0);
        chk("rst_run.idx", {16'd0, bus.tile_idx}, 32'd0);
        chk("rst_run.busy_cycles", bus.busy_cycles, 32'd0);
        step();
        chk_out("rst_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.sched_start = 1'b1;
        bus.num_tiles   = 16'd2;
        step();
        bus.sched_start = 1'b0;
        tile("j2b.t0", 0, 5);
        step();
        tile("j2b.t1", 1, 5);
        step();
        chk_out("j2b.done", 1'b0, 1'b1, 1'b1);
        chk("j2b.busy_cycles", bus.busy_cycles, PERF ? 32'd14 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
